// File: rtl/card_dealer.sv
// card_dealer: deals cards one at a time from a 52-card deck without repeats.
//
// Each deal starts at a pseudo-random deck index taken from a free-running
// 16-bit Galois LFSR. If that card is already dealt, the search steps linearly
// (wrapping 51 -> 0) until it finds an undealt card.
//
// Handshake: dealReq is a one-cycle request that is only accepted in IDLE and
// is never queued. cardValid is a one-cycle strobe that is high in the DELIVER
// state. card and cardValue hold their values until the next delivery.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   synchronous active-high reset, highest priority
//   shuffle        in   pulse: return all 52 cards to the deck, abort any deal
//   dealReq        in   pulse: request one card
//   cardValid      out  pulse: card/cardValue hold a newly dealt card
//   card[5:0]      out  {suit[1:0], rank[3:0]}, rank 1..13
//   cardValue[3:0] out  blackjack points (ace = 1, J/Q/K = 10)
//   cardsRemaining out  undealt card count, 0..52
//   deckEmpty      out  cardsRemaining == 0
//   busy           out  deal in progress (SEARCH or DELIVER)
module card_dealer #(
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter bit          AUTO_RESHUFFLE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       shuffle,
  input  logic       dealReq,
  output logic       cardValid,
  output logic [5:0] card,
  output logic [3:0] cardValue,
  output logic [5:0] cardsRemaining,
  output logic       deckEmpty,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEARCH  = 2'd1,
    DELIVER = 2'd2
  } state_t;

  localparam logic [5:0]  DECK_SIZE = 6'd52;
  localparam logic [5:0]  LAST_IDX  = 6'd51;
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [51:0] used_q, used_d;
  logic [5:0]  idx_q, idx_d;
  logic [5:0]  remaining_q, remaining_d;
  logic [5:0]  card_q, card_d;
  logic [3:0]  value_q, value_d;

  logic [5:0]  start_idx;
  logic [5:0]  probe_card;

  // Deck index -> {suit, rank}: suit = idx / 13, rank = (idx mod 13) + 1.
  function automatic logic [5:0] idx_to_card(input logic [5:0] idx);
    logic [1:0] suit;
    logic [5:0] base;
    logic [5:0] offs;
    if (idx >= 6'd39) begin
      suit = 2'd3;
      base = 6'd39;
    end else if (idx >= 6'd26) begin
      suit = 2'd2;
      base = 6'd26;
    end else if (idx >= 6'd13) begin
      suit = 2'd1;
      base = 6'd13;
    end else begin
      suit = 2'd0;
      base = 6'd0;
    end
    offs = idx - base;
    return {suit, offs[3:0] + 4'd1};
  endfunction

  // Blackjack points: face cards count 10, ace counts 1.
  function automatic logic [3:0] rank_to_value(input logic [3:0] rank);
    return (rank > 4'd10) ? 4'd10 : rank;
  endfunction

  // Folding 52..63 down keeps the start index inside the deck.
  assign start_idx  = (lfsr_q[5:0] >= DECK_SIZE) ? (lfsr_q[5:0] - DECK_SIZE) : lfsr_q[5:0];
  assign probe_card = idx_to_card(idx_q);

  always_comb begin
    state_d     = state_q;
    used_d      = used_q;
    idx_d       = idx_q;
    remaining_d = remaining_q;
    card_d      = card_q;
    value_d     = value_q;

    // Galois LFSR, shift right; runs every cycle so idle time adds entropy.
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_POLY : 16'h0000);

    unique case (state_q)
      IDLE: begin
        if (dealReq) begin
          if (remaining_q != 6'd0) begin
            idx_d   = start_idx;
            state_d = SEARCH;
          end else if (AUTO_RESHUFFLE) begin
            // Refill and start searching in the same cycle.
            used_d      = '0;
            remaining_d = DECK_SIZE;
            idx_d       = start_idx;
            state_d     = SEARCH;
          end
        end
      end

      SEARCH: begin
        if (!used_q[idx_q]) begin
          used_d[idx_q] = 1'b1;
          card_d        = probe_card;
          value_d       = rank_to_value(probe_card[3:0]);
          remaining_d   = remaining_q - 6'd1;
          state_d       = DELIVER;
        end else begin
          idx_d = (idx_q == LAST_IDX) ? 6'd0 : (idx_q + 6'd1);
        end
      end

      DELIVER: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // shuffle overrides everything above, including a hit being loaded this
    // cycle: the card outputs keep their previous delivery.
    if (shuffle) begin
      state_d     = IDLE;
      used_d      = '0;
      remaining_d = DECK_SIZE;
      card_d      = card_q;
      value_d     = value_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lfsr_q      <= LFSR_SEED;
      used_q      <= '0;
      idx_q       <= 6'd0;
      remaining_q <= DECK_SIZE;
      card_q      <= 6'd0;
      value_q     <= 4'd0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      used_q      <= used_d;
      idx_q       <= idx_d;
      remaining_q <= remaining_d;
      card_q      <= card_d;
      value_q     <= value_d;
    end
  end

  assign cardValid      = (state_q == DELIVER);
  assign busy           = (state_q != IDLE);
  assign card           = card_q;
  assign cardValue      = value_q;
  assign cardsRemaining = remaining_q;
  assign deckEmpty      = (remaining_q == 6'd0);

endmodule

// File: tb/tb_card_dealer.sv
module tb_card_dealer;

  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset   = 1'b1;
  logic shuffle = 1'b0;
  logic dealReq = 1'b0;

  // dut: AUTO_RESHUFFLE = 1, dut0: AUTO_RESHUFFLE = 0, same inputs
  logic       cv, empty, busy;
  logic [5:0] card, rem;
  logic [3:0] val;
  logic       cv0, empty0, busy0;
  logic [5:0] card0, rem0;
  logic [3:0] val0;

  card_dealer #(.LFSR_SEED(SEED), .AUTO_RESHUFFLE(1'b1)) dut (
    .clk(clk), .reset(reset), .shuffle(shuffle), .dealReq(dealReq),
    .cardValid(cv), .card(card), .cardValue(val),
    .cardsRemaining(rem), .deckEmpty(empty), .busy(busy)
  );

  card_dealer #(.LFSR_SEED(SEED), .AUTO_RESHUFFLE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .shuffle(shuffle), .dealReq(dealReq),
    .cardValid(cv0), .card(card0), .cardValue(val0),
    .cardsRemaining(rem0), .deckEmpty(empty0), .busy(busy0)
  );

  int total = 0;
  int bad   = 0;

  // Reference model of the LFSR and the deck.
  logic [15:0] m_lfsr = SEED;
  bit          m_used[52];
  int          m_rem = 52;
  bit          seen[64];

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  always @(posedge clk) m_lfsr <= reset ? SEED : lfsr_step(m_lfsr);

  task automatic model_refill();
    for (int i = 0; i < 52; i++) m_used[i] = 1'b0;
    m_rem = 52;
  endtask

  typedef struct {
    int         pulses;
    int         lat;
    int         busy1;
    int         pulses0;
    int         busy0_any;
    logic [5:0] card;
    logic [3:0] val;
    logic [5:0] rem;
    logic [5:0] card_end;
    logic [5:0] e_card;
    logic [3:0] e_val;
    int         e_lat;
    int         e_rem;
  } deal_t;

  // Driver: called at a negedge with the DUT in IDLE. Raises dealReq for one
  // cycle (optionally a second pulse while busy), predicts the dealt card from
  // the model and records what the DUT produced. Returns at a negedge.
  task automatic do_deal(input bit extra_req, output deal_t r);
    int idx, probes;
    logic [1:0] s;
    logic [3:0] rk;
    dealReq = 1'b1;
    idx = int'(m_lfsr[5:0]);
    if (idx >= 52) idx -= 52;
    if (m_rem == 0) model_refill();
    probes = 1;
    while (m_used[idx]) begin
      idx = (idx == 51) ? 0 : idx + 1;
      probes++;
    end
    m_used[idx] = 1'b1;
    m_rem--;
    s  = 2'(idx / 13);
    rk = 4'(idx % 13 + 1);
    r.e_card = {s, rk};
    r.e_val  = (rk > 4'd10) ? 4'd10 : rk;
    r.e_lat  = 1 + probes;
    r.e_rem  = m_rem;
    r.pulses = 0; r.lat = 0; r.busy1 = 0; r.pulses0 = 0; r.busy0_any = 0;
    r.card = '0; r.val = '0; r.rem = '0;
    for (int cyc = 1; cyc <= r.e_lat + 3; cyc++) begin
      @(negedge clk);
      dealReq = (extra_req && cyc == 1);
      if (cyc == 1) r.busy1 = int'(busy);
      if (busy0) r.busy0_any = 1;
      if (cv0) r.pulses0++;
      if (cv) begin
        r.pulses++;
        if (r.pulses == 1) begin
          r.lat  = cyc;
          r.card = card;
          r.val  = val;
          r.rem  = rem;
        end
      end
    end
    dealReq = 1'b0;
    r.card_end = card;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_refill();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_refill();
    total++; if (cv !== 1'b0)    begin bad++; $display("FAIL reset_cardValid got=%b exp=0", cv); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (card !== 6'd0)  begin bad++; $display("FAIL reset_card got=%h exp=00", card); end
    total++; if (val !== 4'd0)   begin bad++; $display("FAIL reset_value got=%0d exp=0", val); end
    total++; if (rem !== 6'd52)  begin bad++; $display("FAIL reset_remaining got=%0d exp=52", rem); end
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL reset_deckEmpty got=%b exp=0", empty); end
    // reset stays high; the next test releases it together with dealReq
  endtask

  task automatic test_first_deal();
    deal_t r;
    reset = 1'b0;
    do_deal(1'b0, r);
    // hand-computed: 0xACE1[5:0] = 33 -> suit 2, rank 8
    total++; if (r.card !== 6'h28) begin bad++; $display("FAIL first_card got=%h exp=28", r.card); end
    total++; if (r.val !== 4'd8)   begin bad++; $display("FAIL first_value got=%0d exp=8", r.val); end
    total++; if (r.lat != 2)       begin bad++; $display("FAIL first_latency got=%0d exp=2", r.lat); end
    total++; if (r.rem !== 6'd51)  begin bad++; $display("FAIL first_remaining got=%0d exp=51", r.rem); end
    total++; if (r.pulses != 1)    begin bad++; $display("FAIL first_pulses got=%0d exp=1", r.pulses); end
    total++; if (r.busy1 != 1)     begin bad++; $display("FAIL first_busy got=%0d exp=1", r.busy1); end
    total++; if (r.card_end !== 6'h28) begin bad++; $display("FAIL first_card_hold got=%h exp=28", r.card_end); end
    for (int i = 0; i < 64; i++) seen[i] = 1'b0;
    seen[6'h28] = 1'b1;
  endtask

  // Remaining 51 cards; the last deals probe past many used slots.
  task automatic test_full_deck();
    deal_t r;
    for (int n = 2; n <= 52; n++) begin
      do_deal(1'b0, r);
      total++; if (r.pulses != 1) begin bad++; $display("FAIL deck_pulses deal=%0d got=%0d exp=1", n, r.pulses); end
      total++; if (r.card !== r.e_card) begin bad++; $display("FAIL deck_card deal=%0d got=%h exp=%h", n, r.card, r.e_card); end
      total++; if (r.val !== r.e_val) begin bad++; $display("FAIL deck_value deal=%0d got=%0d exp=%0d", n, r.val, r.e_val); end
      total++; if (r.lat != r.e_lat) begin bad++; $display("FAIL deck_latency deal=%0d got=%0d exp=%0d", n, r.lat, r.e_lat); end
      total++; if (int'(r.rem) != r.e_rem) begin bad++; $display("FAIL deck_remaining deal=%0d got=%0d exp=%0d", n, r.rem, r.e_rem); end
      total++; if (seen[r.card]) begin bad++; $display("FAIL deck_duplicate deal=%0d got=%h exp=unique", n, r.card); end
      total++; if (r.card[3:0] < 4'd1 || r.card[3:0] > 4'd13) begin bad++; $display("FAIL deck_rank deal=%0d got=%0d exp=1..13", n, r.card[3:0]); end
      seen[r.card] = 1'b1;
    end
    total++; if (rem !== 6'd0)    begin bad++; $display("FAIL deck_end_remaining got=%0d exp=0", rem); end
    total++; if (empty !== 1'b1)  begin bad++; $display("FAIL deck_end_empty got=%b exp=1", empty); end
    total++; if (empty0 !== 1'b1) begin bad++; $display("FAIL deck_end_empty_noauto got=%b exp=1", empty0); end
  endtask

  task automatic test_empty_deck();
    deal_t r;
    do_deal(1'b0, r);
    total++; if (r.pulses0 != 0)   begin bad++; $display("FAIL empty_noauto_valid got=%0d exp=0", r.pulses0); end
    total++; if (r.busy0_any != 0) begin bad++; $display("FAIL empty_noauto_busy got=%0d exp=0", r.busy0_any); end
    total++; if (empty0 !== 1'b1)  begin bad++; $display("FAIL empty_noauto_deckEmpty got=%b exp=1", empty0); end
    total++; if (r.pulses != 1)    begin bad++; $display("FAIL empty_auto_pulses got=%0d exp=1", r.pulses); end
    total++; if (r.rem !== 6'd51)  begin bad++; $display("FAIL empty_auto_remaining got=%0d exp=51", r.rem); end
    total++; if (r.card !== r.e_card) begin bad++; $display("FAIL empty_auto_card got=%h exp=%h", r.card, r.e_card); end
    total++; if (r.lat != r.e_lat) begin bad++; $display("FAIL empty_auto_latency got=%0d exp=%0d", r.lat, r.e_lat); end
    apply_reset();
  endtask

  task automatic test_shuffle_search();
    int pulses;
    logic [5:0] card_before;
    card_before = card;
    dealReq = 1'b1;
    @(negedge clk);
    dealReq = 1'b0;
    shuffle = 1'b1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL shuf_search_busy got=%b exp=1", busy); end
    @(negedge clk);
    shuffle = 1'b0;
    model_refill();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL shuf_search_idle got=%b exp=0", busy); end
    total++; if (rem !== 6'd52) begin bad++; $display("FAIL shuf_search_remaining got=%0d exp=52", rem); end
    pulses = int'(cv);
    repeat (4) begin
      @(negedge clk);
      if (cv) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL shuf_search_valid got=%0d exp=0", pulses); end
    total++; if (card !== card_before) begin bad++; $display("FAIL shuf_search_card got=%h exp=%h", card, card_before); end
  endtask

  task automatic test_shuffle_with_req();
    deal_t r;
    int pulses;
    do_deal(1'b0, r);
    total++; if (r.rem !== 6'd51) begin bad++; $display("FAIL shuf_req_pre_remaining got=%0d exp=51", r.rem); end
    dealReq = 1'b1;
    shuffle = 1'b1;
    @(negedge clk);
    dealReq = 1'b0;
    shuffle = 1'b0;
    model_refill();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL shuf_req_busy got=%b exp=0", busy); end
    total++; if (rem !== 6'd52) begin bad++; $display("FAIL shuf_req_remaining got=%0d exp=52", rem); end
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (cv) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL shuf_req_valid got=%0d exp=0", pulses); end
  endtask

  task automatic test_back_to_back();
    deal_t r;
    deal_t r2;
    do_deal(1'b1, r);
    total++; if (r.pulses != 1) begin bad++; $display("FAIL busy_req_pulses got=%0d exp=1", r.pulses); end
    total++; if (r.rem !== 6'd51) begin bad++; $display("FAIL busy_req_remaining got=%0d exp=51", r.rem); end
    total++; if (rem !== 6'd51) begin bad++; $display("FAIL busy_req_remaining_after got=%0d exp=51", rem); end
    total++; if (r.card !== r.e_card) begin bad++; $display("FAIL busy_req_card got=%h exp=%h", r.card, r.e_card); end
    do_deal(1'b0, r2);
    total++; if (r2.card !== r2.e_card) begin bad++; $display("FAIL b2b_card got=%h exp=%h", r2.card, r2.e_card); end
    total++; if (r2.card === r.card) begin bad++; $display("FAIL b2b_unique got=%h exp=not %h", r2.card, r.card); end
    total++; if (r2.rem !== 6'd50) begin bad++; $display("FAIL b2b_remaining got=%0d exp=50", r2.rem); end
  endtask

  task automatic test_reset_mid_deal();
    int pulses;
    dealReq = 1'b1;
    @(negedge clk);
    dealReq = 1'b0;
    reset = 1'b1;
    pulses = 0;
    @(negedge clk);
    reset = 1'b0;
    model_refill();
    if (cv) pulses++;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    total++; if (rem !== 6'd52) begin bad++; $display("FAIL rst_mid_remaining got=%0d exp=52", rem); end
    total++; if (card !== 6'd0) begin bad++; $display("FAIL rst_mid_card got=%h exp=00", card); end
    repeat (4) begin
      @(negedge clk);
      if (cv) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL rst_mid_valid got=%0d exp=0", pulses); end
  endtask

  initial begin
    test_reset();
    test_first_deal();
    test_full_deck();
    test_empty_deck();
    test_shuffle_search();
    test_shuffle_with_req();
    test_back_to_back();
    test_reset_mid_deal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/card_dealer.md
CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 SHALL have parameter LFSR_SEED, default 16'hACE1, meaning the nonzero reset value of the internal 16-bit LFSR.
REQ-002 SHALL have parameter AUTO_RESHUFFLE, default 1, meaning a deal request on an empty deck refills the deck first instead of being ignored.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port shuffle  input  1  one-cycle pulse; return all 52 cards to the deck.
REQ-006 SHALL have port dealReq  input  1  one-cycle pulse; request one card from the game controller.
REQ-007 SHALL have port cardValid  output  1  one-cycle pulse; card and cardValue hold a newly dealt card.
REQ-008 SHALL have port card  output  6  {suit[1:0], rank[3:0]}, with rank 1..13 (1 = ace, 11..13 = J/Q/K).
REQ-009 SHALL have port cardValue  output  4  blackjack points for card: ace = 1, 2..10 = face value, J/Q/K = 10.
REQ-010 SHALL have port cardsRemaining  output  6  count of undealt cards, 0..52.
REQ-011 SHALL have port deckEmpty  output  1  high when cardsRemaining == 0.
REQ-012 SHALL have port busy  output  1  high while a deal is in progress (SEARCH or DELIVER).

Function
REQ-013 SHALL keep a 52-bit used mask; deck index i (0..51) maps to suit = i/13 and rank = (i mod 13)+1.
REQ-014 SHALL advance a 16-bit Galois LFSR (polynomial 0xB400, shift right) every cycle, including while idle; the LFSR never reaches zero.
REQ-015 SHALL implement FSM states IDLE, SEARCH and DELIVER; busy = (state != IDLE).
REQ-016 In IDLE, on dealReq with cardsRemaining > 0: SHALL load idx = lfsr[5:0], subtract 52 when that value is >= 52, and go to SEARCH.
REQ-017 In SEARCH, if used[idx] == 0: SHALL set used[idx], load card and cardValue, decrement cardsRemaining, and go to DELIVER.
REQ-018 In SEARCH, if used[idx] == 1: SHALL set idx = (idx == 51) ? 0 : idx+1 and stay in SEARCH; worst case is 52 probes.
REQ-019 In DELIVER: SHALL drive cardValid = 1 for exactly one cycle, then return to IDLE.
REQ-020 Latency: when the first probe is free, cardValid SHALL be high in the second cycle after the cycle in which dealReq is sampled; each occupied probe adds one cycle.
REQ-021 card and cardValue SHALL hold their values until the next delivery.
REQ-022 dealReq SHALL be ignored while busy; no request is queued.
REQ-023 dealReq in IDLE with cardsRemaining == 0 and AUTO_RESHUFFLE = 1: SHALL clear the mask, set cardsRemaining = 52, and enter SEARCH the same cycle using the REQ-016 index.
REQ-024 dealReq in IDLE with cardsRemaining == 0 and AUTO_RESHUFFLE = 0: SHALL be ignored; deckEmpty stays 1 and cardValid stays 0.
REQ-025 shuffle in any state: SHALL clear the mask, set cardsRemaining = 52, and go to IDLE.
REQ-026 shuffle during SEARCH or DELIVER: SHALL abort the pending deal; no cardValid occurs and card is unchanged. If a DELIVER-cycle cardValid is already visible, it is that cycle's pulse only.
REQ-027 shuffle and dealReq in the same cycle: shuffle SHALL win and the request SHALL be dropped.
REQ-028 Dealt cards SHALL be unique between refills; 52 consecutive deals after a refill SHALL deliver every card exactly once.

Reset
REQ-029 reset SHALL have priority over all inputs and take effect at the next rising clk edge.
REQ-030 Reset values SHALL be: state = IDLE, used mask = 0, cardsRemaining = 52, deckEmpty = 0, busy = 0, cardValid = 0, card = 6'b0, cardValue = 0, lfsr = LFSR_SEED.
REQ-031 reset asserted mid-SEARCH or mid-DELIVER SHALL abort the deal with no cardValid.

Verification
REQ-032 Reset release, then dealReq in the first cycle with the default seed -> idx = 33, card = {2'd2, 4'd8}, cardValue = 8, cardValid high in the second cycle after the request, cardsRemaining = 51.
REQ-033 52 dealReq pulses, each sent after the previous cardValid -> 52 distinct card codes, no rank 0 or rank above 13, cardsRemaining = 0, deckEmpty = 1.
REQ-034 53rd dealReq with AUTO_RESHUFFLE = 0 -> no cardValid, busy stays 0; with AUTO_RESHUFFLE = 1 -> one card delivered and cardsRemaining = 51.
REQ-035 Force 51 cards used, then dealReq -> SEARCH wraps past index 51 if needed, delivers the only free card, and cardValid latency equals 1 + number of probes.
REQ-036 shuffle pulsed during SEARCH -> no cardValid, state = IDLE next cycle, cardsRemaining = 52; shuffle and dealReq in the same cycle -> no deal.
REQ-037 dealReq pulsed while busy -> exactly one cardValid and cardsRemaining decremented by 1 only.
